booth_control: RTL and testbench

- Sequencer for the radix-2 Booth multiplier.
- Drives the load/shift commands consumed by the multiplier (Q), multiplicand (M) and accumulator (A) registers, and the add/subtract select of the adder/subtractor.
- Each iteration it examines the Booth pair {Q[0], Q[-1]} returned by the Q register, decides add/subtract/none, then orders a combined arithmetic right shift of A:Q.
- It is the command-issuing end of the Q register's CargaQ/DesplazaQ interface.

---
 rtl/booth_control.sv | 50 +++++
 tb/tb_booth_control.sv | 124 ++++++++++++
 2 files changed

// File: rtl/booth_control.sv
// booth_control: radix-2 Booth multiplier sequencer issuing load/add/shift commands per iteration.
module booth_control #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inicio,
  input  logic [1:0]    qpar,
  output logic          CargaM,
  output logic          CargaQ,
  output logic          LimpiaA,
  output logic          CargaA,
  output logic          Resta,
  output logic          DesplazaA,
  output logic          DesplazaQ,
  output logic          ocupado,
  output logic          fin,
  output logic [CW-1:0] cuenta
);
  localparam logic [2:0] REPOSO = 3'd0, CARGA = 3'd1, EVALUA = 3'd2, DESPLAZA = 3'd3, FIN = 3'd4;
  logic [2:0] state, next;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REPOSO;
      cuenta <= '0;
    end else begin
      state  <= next;
      cuenta <= state == CARGA ? CW'(N) : state == DESPLAZA ? cuenta - CW'(1) : state == EVALUA ? cuenta : '0;
    end
  end
  always_comb begin
    next = state == REPOSO   ? (inicio ? CARGA : REPOSO) :
           state == CARGA    ? EVALUA :
           state == EVALUA   ? DESPLAZA :
           state == DESPLAZA ? (cuenta == CW'(1) ? FIN : EVALUA) :
                               REPOSO;
  end
  always_comb begin
    CargaM    = state == CARGA;
    CargaQ    = state == CARGA;
    LimpiaA   = state == CARGA;
    CargaA    = state == EVALUA && (qpar[1] ^ qpar[0]);
    Resta     = state == EVALUA && qpar == 2'b10;
    DesplazaA = state == DESPLAZA;
    DesplazaQ = state == DESPLAZA;
    ocupado   = state == CARGA || state == EVALUA || state == DESPLAZA || state == FIN;
    fin       = state == FIN;
  end
endmodule

// File: tb/tb_booth_control.sv
// tb_booth_control: checks N=4 and N=8 sequencers against a cycle-index model of the Booth schedule.
module tb_booth_control;
  logic clk = 1'b0, reset, inicio;
  logic [1:0] qpar;
  logic m4, q4, la4, ca4, rs4, da4, dq4, oc4, fn4;
  logic m8, q8, la8, ca8, rs8, da8, dq8, oc8, fn8;
  logic [2:0] cu4;
  logic [3:0] cu8;
  logic [12:0] obs4, obs8;
  int cmp = 0, err = 0, k4 = 0, k8 = 0, cyc = 0, last_carga = -1, gap = 0;

  booth_control #(.N(4), .CW(3)) u4 (
    .clk(clk), .reset(reset), .inicio(inicio), .qpar(qpar),
    .CargaM(m4), .CargaQ(q4), .LimpiaA(la4), .CargaA(ca4), .Resta(rs4),
    .DesplazaA(da4), .DesplazaQ(dq4), .ocupado(oc4), .fin(fn4), .cuenta(cu4)
  );
  booth_control #(.N(8), .CW(4)) u8 (
    .clk(clk), .reset(reset), .inicio(inicio), .qpar(qpar),
    .CargaM(m8), .CargaQ(q8), .LimpiaA(la8), .CargaA(ca8), .Resta(rs8),
    .DesplazaA(da8), .DesplazaQ(dq8), .ocupado(oc8), .fin(fn8), .cuenta(cu8)
  );

  assign obs4 = {m4, q4, la4, ca4, rs4, da4, dq4, oc4, fn4, 1'b0, cu4};
  assign obs8 = {m8, q8, la8, ca8, rs8, da8, dq8, oc8, fn8, cu8};

  always #5 clk = ~clk;

  // k = cycles since the inicio-sampling edge (0 = idle); 1 load, then evaluate/shift pairs, then done
  function automatic logic [12:0] model(int k, int n, logic [1:0] q);
    logic [12:0] v;
    v = '0;
    if (k == 1) begin
      v[12:10] = 3'b111;
      v[5] = 1'b1;
    end else if (k >= 2 && k <= 2 * n + 1) begin
      v[5] = 1'b1;
      v[3:0] = 4'(n - (k - 2) / 2);
      if (k % 2 == 0) begin
        v[9] = (q == 2'b01) || (q == 2'b10);
        v[8] = (q == 2'b10);
      end else v[7:6] = 2'b11;
    end else if (k == 2 * n + 2) v[5:4] = 2'b11;
    return v;
  endfunction

  function automatic int advance(int k, int n, logic i, logic r);
    if (r) return 0;
    if (k == 0) return i ? 1 : 0;
    if (k == 2 * n + 2) return 0;
    return k + 1;
  endfunction

  task automatic chk(string tag, logic [12:0] o, logic [12:0] e);
    cmp++;
    assert (o === e) else begin
      err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic tick(logic r, logic i, logic [1:0] q);
    reset = r;
    inicio = i;
    qpar = q;
    @(negedge clk);
    chk("dut4", obs4, model(k4, 4, q));
    chk("dut8", obs8, model(k8, 8, q));
    chk("excl", {7'b0, ca4 & da4, q4 & dq4, la4 & ca4, ca8 & da8, q8 & dq8, la8 & ca8}, 13'd0);
    if (m4) begin
      if (last_carga >= 0) gap = cyc - last_carga;
      last_carga = cyc;
    end
    @(posedge clk);
    k4 = advance(k4, 4, i, r);
    k8 = advance(k8, 8, i, r);
    cyc++;
    #1;
  endtask

  task automatic op4(logic [1:0] a, logic [1:0] b, logic [1:0] c, logic [1:0] d);
    logic [1:0] l [4];
    l = '{a, b, c, d};
    tick(1'b0, 1'b1, 2'($urandom));
    for (int k = 1; k <= 10; k++)
      tick(1'b0, 1'b0, (k % 2 == 0 && k <= 8) ? l[(k - 2) / 2] : 2'($urandom));
    repeat (12) tick(1'b0, 1'b0, 2'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    inicio = 1'b0;
    qpar = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    tick(1'b0, 1'b0, 2'b00);
    op4(2'b00, 2'b00, 2'b00, 2'b00);
    op4(2'b00, 2'b10, 2'b11, 2'b11);
    op4(2'b01, 2'b10, 2'b01, 2'b10);
    // reset lands in the third EVALUA, then a fresh start must reach CARGA
    tick(1'b0, 1'b1, 2'b00);
    repeat (5) tick(1'b0, 1'b0, 2'($urandom));
    tick(1'b1, 1'b0, 2'b10);
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b00);
    repeat (20) tick(1'b0, 1'b0, 2'($urandom));
    last_carga = -1;
    gap = 0;
    repeat (30) tick(1'b0, 1'b1, 2'($urandom));
    chk("carga_gap", 13'(gap), 13'd11);
    repeat (20) tick(1'b0, 1'b0, 2'($urandom));
    force u8.state = 3'd7;
    @(negedge clk);
    chk("illegal_out", obs8, 13'd0);
    release u8.state;
    @(posedge clk);
    cyc++;
    #1;
    chk("illegal_recover", 13'(u8.state), 13'd0);
    tick(1'b0, 1'b0, 2'b00);
    repeat (400) tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, 2'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
